// File: rtl/audio_tone_seq_if.sv
// Control/sample bundle between the tone sequencer and its neighbours
// (button logic drives requests, DAC serialiser consumes AUDIO_DATA).
interface audio_tone_seq_if;
  logic        SAMPLE_TICK;
  logic        PLAY;
  logic        STOP;
  logic        BUSY;
  logic        DONE;
  logic [2:0]  NOTE_IDX;
  logic [11:0] AUDIO_DATA;

  modport master (
    output SAMPLE_TICK, PLAY, STOP,
    input  BUSY, DONE, NOTE_IDX, AUDIO_DATA
  );

  modport slave (
    input  SAMPLE_TICK, PLAY, STOP,
    output BUSY, DONE, NOTE_IDX, AUDIO_DATA
  );
endinterface

// File: rtl/audio_tone_seq.sv
// Fixed 8-note square-wave melody source for the Pmod DAC path.
// Optional feature: define AUDIO_ENVELOPE_EN for a stepped release over the last quarter of each note.
module audio_tone_seq #(
  parameter logic [11:0]     AMPLITUDE  = 12'h7FF,
  parameter int unsigned     NOTE_TICKS = 4000,
  parameter int unsigned     GAP_TICKS  = 400,
  parameter int unsigned     NUM_NOTES  = 8,
  parameter logic [8*17-1:0] HP_TABLE   = {17'd47755, 17'd50607, 17'd56818, 17'd63776,
                                           17'd71633, 17'd75873, 17'd85179, 17'd95602}
) (
  input  logic             CLOCK,
  input  logic             RST_N,
  audio_tone_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP, S_LAST} state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_idx;
  logic [11:0] r_audio;
  logic        r_phase;
  logic [16:0] r_hp_cnt;
  logic [12:0] r_dur_cnt;
  logic [12:0] r_gap_cnt;

  logic [16:0] w_hp;
  logic        w_hp_last;
  logic        w_last_note;
  logic        w_dur_end;
  logic        w_gap_end;
  logic [11:0] w_amp;

  always_comb begin
    w_hp        = HP_TABLE[17*32'(r_idx) +: 17];
    w_hp_last   = (r_hp_cnt == w_hp - 17'd1);
    w_last_note = (r_idx == 3'(NUM_NOTES - 1));
    w_dur_end   = (r_dur_cnt == 13'(NOTE_TICKS - 1));
    w_gap_end   = (r_gap_cnt == 13'(GAP_TICKS - 1));
  end

`ifdef AUDIO_ENVELOPE_EN
  localparam int unsigned LQ_START = 3 * NOTE_TICKS / 4;
  localparam int unsigned QUARTER  = NOTE_TICKS / 4;

  // r_env_acc tracks 4*r; comparing against Q, 2Q, 3Q yields 1 + r*4/Q capped at 4
  logic        r_env_on;
  logic [14:0] r_env_acc;
  logic [2:0]  w_shift;

  always_comb begin
    w_shift = 3'd0;
    if (r_env_on) begin
      w_shift = 3'd1;
      if (32'(r_env_acc) >= QUARTER)     w_shift = 3'd2;
      if (32'(r_env_acc) >= 2 * QUARTER) w_shift = 3'd3;
      if (32'(r_env_acc) >= 3 * QUARTER) w_shift = 3'd4;
    end
    w_amp = AMPLITUDE >> w_shift;
  end

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_env_on  <= 1'b0;
      r_env_acc <= '0;
    end else if (bus.STOP || r_state != S_NOTE) begin
      r_env_on  <= (LQ_START == 0);
      r_env_acc <= '0;
    end else if (bus.SAMPLE_TICK) begin
      if (w_dur_end) begin
        r_env_on  <= (LQ_START == 0);
        r_env_acc <= '0;
      end else if (r_env_on) begin
        r_env_acc <= r_env_acc + 15'd4;
      end else if (r_dur_cnt == 13'(LQ_START - 1)) begin
        r_env_on <= 1'b1;
      end
    end
  end
`else
  always_comb w_amp = AMPLITUDE;
`endif

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= '0;
      r_audio   <= '0;
      r_phase   <= 1'b0;
      r_hp_cnt  <= '0;
      r_dur_cnt <= '0;
      r_gap_cnt <= '0;
    end else if (bus.STOP) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= '0;
      r_audio   <= '0;
      r_phase   <= 1'b0;
      r_hp_cnt  <= '0;
      r_dur_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      // sample uses the state/phase in force before this edge's transition
      if (bus.SAMPLE_TICK)
        r_audio <= (r_state == S_NOTE && r_phase) ? w_amp : '0;
      case (r_state)
        S_IDLE: begin
          if (bus.PLAY) begin
            r_state   <= S_NOTE;
            r_busy    <= 1'b1;
            r_idx     <= '0;
            r_phase   <= 1'b1;
            r_hp_cnt  <= '0;
            r_dur_cnt <= '0;
            r_gap_cnt <= '0;
          end
        end
        S_NOTE: begin
          if (w_hp_last) begin
            r_hp_cnt <= '0;
            r_phase  <= ~r_phase;
          end else begin
            r_hp_cnt <= r_hp_cnt + 17'd1;
          end
          if (bus.SAMPLE_TICK) begin
            if (w_dur_end) begin
              r_dur_cnt <= '0;
              if (w_last_note) begin
                r_state <= S_LAST;
                r_done  <= 1'b1;
              end else if (GAP_TICKS > 0) begin
                r_state   <= S_GAP;
                r_phase   <= 1'b0;
                r_gap_cnt <= '0;
              end else begin
                r_idx    <= r_idx + 3'd1;
                r_phase  <= 1'b1;
                r_hp_cnt <= '0;
              end
            end else begin
              r_dur_cnt <= r_dur_cnt + 13'd1;
            end
          end
        end
        S_GAP: begin
          if (bus.SAMPLE_TICK) begin
            if (w_gap_end) begin
              r_state   <= S_NOTE;
              r_idx     <= r_idx + 3'd1;
              r_phase   <= 1'b1;
              r_hp_cnt  <= '0;
              r_gap_cnt <= '0;
            end else begin
              r_gap_cnt <= r_gap_cnt + 13'd1;
            end
          end
        end
        S_LAST: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.BUSY       = r_busy;
  assign bus.DONE       = r_done;
  assign bus.NOTE_IDX   = r_idx;
  assign bus.AUDIO_DATA = r_audio;

endmodule
